// File: rtl/div_stall_unit.sv
// rtl/div_stall_unit.sv - multi-cycle restoring divider with EX-stage stall request
module div_stall_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_for_ex
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIVZERO = 2'd1;
    localparam logic [1:0] ON      = 2'd2;
    localparam logic [1:0] END     = 2'd3;

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic              sgn_r;
    logic              a_neg;
    logic              b_neg;

    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   trial;
    logic [DATA_W+1:0] diff;
    logic              borrow;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] fix_rem;
    logic [DATA_W-1:0] fix_quo;

    // Operand magnitudes at accept; only signed requests take the absolute value.
    always_comb begin
        abs_a = opdata1_i;
        abs_b = opdata2_i;
        if (signed_i && opdata1_i[DATA_W-1]) begin
            abs_a = {DATA_W{1'b0}} - opdata1_i;
        end
        if (signed_i && opdata2_i[DATA_W-1]) begin
            abs_b = {DATA_W{1'b0}} - opdata2_i;
        end
    end

    // One restoring step on the shifted {rem,quo}; the 33-bit trial keeps the bit shifted out of rem.
    always_comb begin
        trial    = {rem, quo[DATA_W-1]};
        diff     = {1'b0, trial} - {2'b00, dvs};
        borrow   = diff[DATA_W+1];
        step_rem = borrow ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
        step_quo = {quo[DATA_W-2:0], ~borrow};
    end

    // Sign fixup of the final step: quotient negative on sign mismatch, remainder follows dividend.
    always_comb begin
        fix_quo = step_quo;
        fix_rem = step_rem;
        if (sgn_r && (a_neg ^ b_neg)) begin
            fix_quo = {DATA_W{1'b0}} - step_quo;
        end
        if (sgn_r && a_neg) begin
            fix_rem = {DATA_W{1'b0}} - step_rem;
        end
    end

    // Stall the pipeline from the accepting cycle until the cycle before the result appears.
    always_comb begin
        stallreq_for_ex = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stallreq_for_ex = start_i && !annul_i;
                DIVZERO: stallreq_for_ex = 1'b1;
                ON:      stallreq_for_ex = 1'b1;
                default: stallreq_for_ex = 1'b0;
            endcase
        end
    end

    // Control FSM, datapath registers and the registered result/ready pair loaded on entry to END.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sgn_r    <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            if (opdata2_i == '0) begin
                                state <= DIVZERO;
                            end else begin
                                rem   <= '0;
                                quo   <= abs_a;
                                dvs   <= abs_b;
                                sgn_r <= signed_i;
                                a_neg <= signed_i & opdata1_i[DATA_W-1];
                                b_neg <= signed_i & opdata2_i[DATA_W-1];
                                cnt   <= 6'd0;
                                state <= ON;
                            end
                        end
                    end
                    DIVZERO: begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                    ON: begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            result_o <= {fix_rem, fix_quo};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_stall_unit.sv
// tb/tb_div_stall_unit.sv - directed self-checking bench for div_stall_unit
module tb_div_stall_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_for_ex;

    int checks = 0;
    int errors = 0;

    div_stall_unit #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .signed_i        (signed_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .annul_i         (annul_i),
        .result_o        (result_o),
        .ready_o         (ready_o),
        .stallreq_for_ex (stallreq_for_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept at cycle 0, check stall through the run, ready/result at the final cycle, then hold.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [63:0] exp);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        start_i   = 1'b1;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        chk({tag, "_stall_c0"}, {63'd0, stallreq_for_ex}, 64'd1);
        for (int c = 1; c < lat; c++) begin
            step();
            if (c == 1) begin
                opdata1_i = ~a;
                opdata2_i = 32'h0000_1234;
                signed_i  = ~sg;
            end
            chk({tag, "_stall_run"}, {63'd0, stallreq_for_ex}, 64'd1);
            chk({tag, "_ready_run"}, {63'd0, ready_o}, 64'd0);
        end
        step();
        chk({tag, "_ready_end"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_stall_end"}, {63'd0, stallreq_for_ex}, 64'd0);
        chk({tag, "_result"}, result_o, exp);
        start_i = 1'b0;
        step();
        chk({tag, "_ready_after"}, {63'd0, ready_o}, 64'd0);
        chk({tag, "_result_hold"}, result_o, exp);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;

        // Reset state, and stall suppressed while reset is asserted
        step();
        step();
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        #1;
        chk("rst_stall", {63'd0, stallreq_for_ex}, 64'd0);
        step();
        rst     = 1'b0;
        start_i = 1'b0;
        step();

        // Directed divisions
        do_div("u100_7",    32'd100,       32'd7,         1'b0, 64'h00000002_0000000E);
        do_div("s_m7_2",    32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        do_div("u5_0",      32'd5,         32'd0,         1'b0, 64'h0);
        do_div("s5_0",      32'd5,         32'd0,         1'b1, 64'h0);
        do_div("s_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000);
        do_div("u_max_1",   32'hFFFF_FFFF, 32'd1,         1'b0, 64'h00000000_FFFFFFFF);
        do_div("s7_m2",     32'd7,         32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD);
        do_div("u_m7_2",    32'hFFFF_FFF9, 32'd2,         1'b0, 64'h00000001_7FFFFFFC);

        // Annul has priority over start in IDLE
        start_i   = 1'b1;
        annul_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        #1;
        chk("annul_prio_stall", {63'd0, stallreq_for_ex}, 64'd0);
        step();
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        chk("annul_prio_idle", {63'd0, stallreq_for_ex}, 64'd0);
        step();

        // Annul at cycle 10 of 100/7: back to IDLE, no ready, result untouched
        start_i = 1'b1;
        #1;
        chk("annul_stall_c0", {63'd0, stallreq_for_ex}, 64'd1);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("annul_stall_run", {63'd0, stallreq_for_ex}, 64'd1);
        end
        annul_i = 1'b1;
        step();
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        chk("annul_stall_c11", {63'd0, stallreq_for_ex}, 64'd0);
        for (int c = 0; c < 30; c++) begin
            step();
            chk("annul_no_ready", {63'd0, ready_o}, 64'd0);
        end
        chk("annul_result_hold", result_o, 64'h00000001_7FFFFFFC);

        // Reset at cycle 20 of 100/7, then a fresh 9/3
        start_i = 1'b1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            step();
        end
        chk("rst20_stall_pre", {63'd0, stallreq_for_ex}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst20_stall_rst", {63'd0, stallreq_for_ex}, 64'd0);
        step();
        chk("rst20_result", result_o, 64'd0);
        chk("rst20_ready", {63'd0, ready_o}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk("rst20_idle", {63'd0, stallreq_for_ex}, 64'd0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("rst20_no_ready", {63'd0, ready_o}, 64'd0);
        end
        do_div("u9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
